// File: rtl/l1_bus_arbiter.sv
// Round-robin arbiter for the shared L1 snooping bus: one-hot grant, hold until
// release or watchdog expiry, one GAP turnaround cycle, master offset broadcast.
module l1_bus_arbiter #(
  parameter int unsigned NUM_CACHES      = 4,
  parameter int unsigned MAX_OFFSET_BITS = 3,
  parameter int unsigned TIMEOUT         = 255,
  localparam int unsigned OFFSET_W = $clog2(MAX_OFFSET_BITS) + 1,
  localparam int unsigned ID_W     = $clog2(NUM_CACHES),
  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CACHES-1:0]          bus_request,
  input  logic [NUM_CACHES*OFFSET_W-1:0] active_offset_flat,
  output logic [NUM_CACHES-1:0]          bus_master,
  output logic                           req_ready,
  output logic [OFFSET_W-1:0]            curr_offset,
  output logic [ID_W-1:0]                grant_id,
  output logic                           timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam bit              WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CACHES - 1);

  state_e                state_q, state_d;
  logic [NUM_CACHES-1:0] bus_master_q, bus_master_d;
  logic                  req_ready_q, req_ready_d;
  logic [OFFSET_W-1:0]   curr_offset_q, curr_offset_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [OFFSET_W-1:0]   offs [NUM_CACHES];
  logic                  win_vld;
  logic [ID_W-1:0]       win_id;
  logic                  hi_vld, lo_vld;
  logic [ID_W-1:0]       hi_id, lo_id;
  logic                  wdog_hit;
  logic                  release_hit;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CACHES; i++) begin
      offs[i] = active_offset_flat[i*OFFSET_W +: OFFSET_W];
    end
  end

  // Rotating priority: lowest requester at or above the pointer wins, else the
  // lowest requester below it (the wrap-around part of the search).
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int unsigned j = 0; j < NUM_CACHES; j++) begin
      if (bus_request[j]) begin
        if (j >= 32'(ptr_q)) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_id  = ID_W'(j);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_id  = ID_W'(j);
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win_id  = hi_vld ? hi_id : lo_id;
  end

  assign release_hit = !bus_request[grant_id_q];
  assign wdog_hit    = WDOG_EN && (cnt_q == CNT_LAST) && bus_request[grant_id_q];

  always_comb begin
    state_d       = state_q;
    bus_master_d  = bus_master_q;
    req_ready_d   = req_ready_q;
    curr_offset_d = curr_offset_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d   = 1'b1;
        bus_master_d  = '0;
        curr_offset_d = '0;
        if (win_vld) begin
          state_d              = ST_GRANT;
          bus_master_d         = '0;
          bus_master_d[win_id] = 1'b1;
          grant_id_d           = win_id;
          req_ready_d          = 1'b0;
          cnt_d                = '0;
          curr_offset_d        = offs[win_id];
        end
      end

      ST_GRANT: begin
        curr_offset_d = offs[grant_id_q];
        if (release_hit || wdog_hit) begin
          state_d       = ST_GAP;
          bus_master_d  = '0;
          curr_offset_d = '0;
          timeout_err_d = wdog_hit;
          ptr_d         = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        state_d       = ST_IDLE;
        bus_master_d  = '0;
        req_ready_d   = 1'b1;
        curr_offset_d = '0;
      end

      default: begin
        state_d       = ST_IDLE;
        bus_master_d  = '0;
        req_ready_d   = 1'b1;
        curr_offset_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bus_master_q  <= '0;
      req_ready_q   <= 1'b1;
      curr_offset_q <= '0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bus_master_q  <= bus_master_d;
      req_ready_q   <= req_ready_d;
      curr_offset_q <= curr_offset_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus_master  = bus_master_q;
  assign req_ready   = req_ready_q;
  assign curr_offset = curr_offset_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

  a_grant_onehot0 : assert property (@(posedge clock) disable iff (reset)
    $onehot0(bus_master_q));
  a_ready_no_grant : assert property (@(posedge clock) disable iff (reset)
    req_ready_q |-> (bus_master_q == '0));

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Directed bench for l1_bus_arbiter (4 caches, 3-bit offsets, 8-cycle watchdog).
module tb_l1_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bus_request;
  logic [2:0]  off [4];
  logic [11:0] active_offset_flat;
  logic [3:0]  bus_master;
  logic        req_ready;
  logic [2:0]  curr_offset;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign active_offset_flat = {off[3], off[2], off[1], off[0]};

  l1_bus_arbiter #(
    .NUM_CACHES      (4),
    .MAX_OFFSET_BITS (3),
    .TIMEOUT         (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .bus_request        (bus_request),
    .active_offset_flat (active_offset_flat),
    .bus_master         (bus_master),
    .req_ready          (req_ready),
    .curr_offset        (curr_offset),
    .grant_id           (grant_id),
    .timeout_err        (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL sim_timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int unsigned exp_id [5];
    logic [3:0]  exp_bm;
    exp_id = '{0, 1, 2, 3, 0};

    bus_request = '0;
    off[0] = 3'd0;
    off[1] = 3'd5;
    off[2] = 3'd6;
    off[3] = 3'd7;

    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_bm",  bus_master,  4'b0000);
    chk("rst_rdy", req_ready,   1'b1);
    chk("rst_off", curr_offset, 3'd0);
    chk("rst_gid", grant_id,    2'd0);
    chk("rst_to",  timeout_err, 1'b0);
    #6 reset = 1'b0;
    tick();

    // Single requester, held 5 cycles
    bus_request = 4'b0100;
    tick();
    chk("t1_bm",  bus_master, 4'b0100);
    chk("t1_gid", grant_id,   2'd2);
    chk("t1_rdy", req_ready,  1'b0);
    repeat (4) begin
      tick();
      chk("t1_hold", bus_master, 4'b0100);
    end
    bus_request = '0;
    tick();
    chk("t1_gap_bm",  bus_master, 4'b0000);
    chk("t1_gap_rdy", req_ready,  1'b0);
    tick();
    chk("t1_idle_rdy", req_ready,  1'b1);
    chk("t1_idle_bm",  bus_master, 4'b0000);

    // Round-robin rotation from pointer 0
    do_reset();
    bus_request = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_bm = 4'b0001 << exp_id[n];
      tick();
      chk("rr_bm",  bus_master, exp_bm);
      chk("rr_gid", grant_id,   exp_id[n]);
      tick();
      tick();
      bus_request[exp_id[n]] = 1'b0;
      tick();
      chk("rr_gap_bm",  bus_master, 4'b0000);
      chk("rr_gap_rdy", req_ready,  1'b0);
      bus_request = 4'b1111;
      tick();
      chk("rr_idle_rdy", req_ready, 1'b1);
    end
    bus_request = '0;
    tick();

    // Pointer wrap: 3 granted and released, then 1001 must go to cache 0
    bus_request = 4'b1000;
    tick();
    chk("wrap3_bm",  bus_master, 4'b1000);
    chk("wrap3_gid", grant_id,   2'd3);
    bus_request = '0;
    tick();
    tick();
    bus_request = 4'b1001;
    tick();
    chk("wrap_bm",  bus_master, 4'b0001);
    chk("wrap_gid", grant_id,   2'd0);
    bus_request = '0;
    tick();
    tick();

    // Watchdog: cache 1 never releases, cache 2 waiting
    bus_request = 4'b0110;
    tick();
    chk("wd_bm0",  bus_master, 4'b0010);
    chk("wd_gid0", grant_id,   2'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_hold",    bus_master,  4'b0010);
      chk("wd_hold_to", timeout_err, 1'b0);
    end
    tick();
    chk("wd_bm",  bus_master,  4'b0000);
    chk("wd_err", timeout_err, 1'b1);
    chk("wd_rdy", req_ready,   1'b0);
    tick();
    chk("wd_err_clr", timeout_err, 1'b0);
    chk("wd_idle",    req_ready,   1'b1);
    tick();
    chk("wd_next_bm",  bus_master, 4'b0100);
    chk("wd_next_gid", grant_id,   2'd2);
    bus_request = 4'b0010;
    tick();
    tick();
    tick();
    chk("wd_back_bm", bus_master, 4'b0010);
    bus_request = '0;
    tick();
    tick();

    // Offset broadcast from cache 0 (other caches carry distinct offsets)
    off[0] = 3'd0;
    bus_request = 4'b0001;
    tick();
    chk("off_gnt", bus_master,  4'b0001);
    chk("off_0",   curr_offset, 3'd0);
    for (int v = 1; v < 4; v++) begin
      off[0] = 3'(v);
      tick();
      chk("off_step", curr_offset, 3'(v));
    end
    bus_request = '0;
    tick();
    chk("off_rel",    curr_offset, 3'd0);
    chk("off_rel_bm", bus_master,  4'b0000);
    tick();

    // Asynchronous reset while cache 2 holds the bus
    bus_request = 4'b0100;
    tick();
    chk("ar_gnt", bus_master, 4'b0100);
    tick();
    #3 reset = 1'b1;
    #1;
    chk("ar_bm",  bus_master, 4'b0000);
    chk("ar_rdy", req_ready,  1'b1);
    chk("ar_gid", grant_id,   2'd0);
    reset = 1'b0;
    bus_request = 4'b1100;
    tick();
    chk("ar_bm2",  bus_master, 4'b0100);
    chk("ar_gid2", grant_id,   2'd2);
    bus_request = '0;
    tick();
    tick();

    // Pointer returns to 0 on reset: 1010 must now pick cache 1, not 3
    do_reset();
    bus_request = 4'b1010;
    tick();
    chk("ptr_rst_bm", bus_master, 4'b0010);
    bus_request = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
